qbert_move_ctrl: RTL and testbench

Move sequencer for the Q*bert sprite layer. It accepts direction requests from the accelerometer/NIOS path and computes the next one-hot cube position on the 28-cube pyramid. It flags off-pyramid jumps, drives the sprite layer's jump command and handshakes on its `done_move`. It also owns position, visited-cube map, lives and win detection.

---
 rtl/qbert_move_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_qbert_move_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qbert_move_ctrl.sv
// qbert_move_ctrl: move sequencer for the Q*bert sprite layer.
// Handshake with the layer: a jump command on e_jump_qb is considered taken once
// done_move falls (animation running) and finished once done_move rises again;
// dir_valid is a single-cycle strobe that is accepted only in READY when the
// layer is idle, otherwise it is dropped.
module qbert_move_ctrl #(
    parameter int LIVES          = 3,
    parameter int LAUNCH_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_start_qb,
    input  logic [2:0]  dir_req,
    input  logic        dir_valid,
    input  logic        done_move,
    input  logic [2:0]  state_qb,
    input  logic [2:0]  game_qb,
    output logic [27:0] position_qb,
    output logic [27:0] e_next_qb,
    output logic [2:0]  e_jump_qb,
    output logic        e_bad_jump,
    output logic        e_win_qb,
    output logic [27:0] visited,
    output logic [1:0]  lives,
    output logic        game_over,
    output logic [15:0] jump_count,
    output logic        busy
);

    localparam int TW = $clog2(LAUNCH_TIMEOUT + 1);

    localparam logic [2:0] DIR_DR = 3'b001;
    localparam logic [2:0] DIR_DL = 3'b010;
    localparam logic [2:0] DIR_UR = 3'b011;
    localparam logic [2:0] DIR_UL = 3'b100;

    localparam logic [2:0] LAYER_START  = 3'b000;
    localparam logic [2:0] LAYER_IDLE   = 3'b010;
    localparam logic [2:0] LAYER_SAUCER = 3'b011;

    typedef enum logic [2:0] {
        READY   = 3'd0,
        ISSUE   = 3'd1,
        LAUNCH  = 3'd2,
        MOVING  = 3'd3,
        COMMIT  = 3'd4,
        RECOVER = 3'd5,
        OVER    = 3'd6
    } state_t;

    state_t        r_state;
    logic [2:0]    r_row, r_col;
    logic [2:0]    r_nrow, r_ncol;
    logic [2:0]    r_dir;
    logic [TW-1:0] r_timer;
    logic          r_seen_start;
    logic [27:0]   r_position, r_next, r_visited;
    logic [2:0]    r_jump;
    logic          r_bad, r_win, r_game_over, r_busy;
    logic [1:0]    r_lives;
    logic [15:0]   r_jump_count;

    logic [2:0]    w_nrow, w_ncol;
    logic          w_off;
    logic [27:0]   w_next;
    logic          w_legal, w_accept;

    // One-hot cube for (row, col): index = row*(row-1)/2 + col.
    function automatic logic [27:0] cube_onehot(input logic [2:0] row, input logic [2:0] col);
        logic [5:0] w_r;
        logic [5:0] w_tri;
        w_r   = {3'b000, row};
        w_tri = (w_r * (w_r - 6'd1)) >> 1;
        return 28'd1 << (w_tri + {3'b000, col});
    endfunction

    // Target cube and off-pyramid detection for the captured direction.
    always_comb begin
        w_nrow = r_row;
        w_ncol = r_col;
        w_off  = 1'b1;
        case (r_dir)
            DIR_DR: begin w_nrow = r_row + 3'd1; w_ncol = r_col;        w_off = (r_row == 3'd7); end
            DIR_DL: begin w_nrow = r_row + 3'd1; w_ncol = r_col + 3'd1; w_off = (r_row == 3'd7); end
            DIR_UR: begin w_nrow = r_row - 3'd1; w_ncol = r_col - 3'd1; w_off = (r_col == 3'd0); end
            DIR_UL: begin w_nrow = r_row - 3'd1; w_ncol = r_col;        w_off = (r_col == r_row - 3'd1); end
            default: ;
        endcase
        w_next = w_off ? 28'd0 : cube_onehot(w_nrow, w_ncol);
    end

    assign w_legal  = (dir_req >= DIR_DR) && (dir_req <= DIR_UL);
    assign w_accept = dir_valid && w_legal && (game_qb == 3'b000) && (state_qb == LAYER_IDLE)
                    && done_move && !r_game_over && !r_win;

    // Move sequencer FSM; restart has the same effect as reset and wins over everything.
    always_ff @(posedge clk) begin
        if (reset || e_start_qb) begin
            r_state      <= READY;
            r_row        <= 3'd1;
            r_col        <= 3'd0;
            r_nrow       <= 3'd1;
            r_ncol       <= 3'd0;
            r_dir        <= 3'd0;
            r_timer      <= '0;
            r_seen_start <= 1'b0;
            r_position   <= 28'h1;
            r_next       <= 28'h1;
            r_visited    <= 28'h1;
            r_jump       <= 3'd0;
            r_bad        <= 1'b0;
            r_win        <= 1'b0;
            r_lives      <= 2'(LIVES);
            r_game_over  <= 1'b0;
            r_jump_count <= 16'd0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                READY: begin
                    if (state_qb == LAYER_SAUCER) begin
                        r_state      <= RECOVER;
                        r_seen_start <= 1'b0;
                        r_busy       <= 1'b1;
                    end else if (w_accept) begin
                        r_dir   <= dir_req;
                        r_state <= ISSUE;
                        r_busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_jump  <= r_dir;
                    r_next  <= w_next;
                    r_bad   <= w_off;
                    r_win   <= !w_off && ((r_visited | w_next) == 28'hFFFFFFF);
                    r_nrow  <= w_nrow;
                    r_ncol  <= w_ncol;
                    r_timer <= '0;
                    r_state <= LAUNCH;
                end
                LAUNCH: begin
                    if (!done_move) begin
                        r_state <= MOVING;
                    end else if (r_timer == TW'(LAUNCH_TIMEOUT - 1)) begin
                        // Layer never took the jump: abandon it.
                        r_jump  <= 3'd0;
                        r_bad   <= 1'b0;
                        r_win   <= 1'b0;
                        r_state <= READY;
                        r_busy  <= 1'b0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                MOVING: begin
                    if (done_move) r_state <= COMMIT;
                end
                COMMIT: begin
                    r_jump <= 3'd0;
                    if (!r_bad) begin
                        r_position   <= r_next;
                        r_row        <= r_nrow;
                        r_col        <= r_ncol;
                        r_visited    <= r_visited | r_next;
                        r_jump_count <= r_jump_count + 16'd1;
                        r_state      <= READY;
                        r_busy       <= 1'b0;
                    end else begin
                        r_lives <= r_lives - 2'd1;
                        if (r_lives == 2'd1) begin
                            r_state     <= OVER;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state      <= RECOVER;
                            r_seen_start <= 1'b0;
                        end
                    end
                end
                RECOVER: begin
                    // Wait for the layer to restart (START then IDLE) before respawning at TOP.
                    if (state_qb == LAYER_START) begin
                        r_seen_start <= 1'b1;
                    end else if (r_seen_start && (state_qb == LAYER_IDLE)) begin
                        r_position <= 28'h1;
                        r_row      <= 3'd1;
                        r_col      <= 3'd0;
                        r_next     <= 28'h1;
                        r_bad      <= 1'b0;
                        r_state    <= READY;
                        r_busy     <= 1'b0;
                    end
                end
                OVER: ;
                default: begin
                    r_state <= READY;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign position_qb = r_position;
    assign e_next_qb   = r_next;
    assign e_jump_qb   = r_jump;
    assign e_bad_jump  = r_bad;
    assign e_win_qb    = r_win;
    assign visited     = r_visited;
    assign lives       = r_lives;
    assign game_over   = r_game_over;
    assign jump_count  = r_jump_count;
    assign busy        = r_busy;

endmodule

// File: tb/tb_qbert_move_ctrl.sv
// Directed bench for qbert_move_ctrl with a hand-driven sprite layer.
module tb_qbert_move_ctrl;

    logic        clk = 1'b0;
    logic        reset, e_start_qb, dir_valid, done_move;
    logic [2:0]  dir_req, state_qb, game_qb;
    logic [27:0] position_qb, e_next_qb, visited;
    logic [2:0]  e_jump_qb;
    logic        e_bad_jump, e_win_qb, game_over, busy;
    logic [1:0]  lives;
    logic [15:0] jump_count;

    int n_total = 0;
    int n_bad   = 0;

    logic [2:0] path [30];

    qbert_move_ctrl dut (
        .clk(clk), .reset(reset), .e_start_qb(e_start_qb),
        .dir_req(dir_req), .dir_valid(dir_valid), .done_move(done_move),
        .state_qb(state_qb), .game_qb(game_qb),
        .position_qb(position_qb), .e_next_qb(e_next_qb), .e_jump_qb(e_jump_qb),
        .e_bad_jump(e_bad_jump), .e_win_qb(e_win_qb), .visited(visited),
        .lives(lives), .game_over(game_over), .jump_count(jump_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic restart();
        e_start_qb = 1'b1;
        tick();
        e_start_qb = 1'b0;
    endtask

    task automatic request(input logic [2:0] d);
        dir_req   = d;
        dir_valid = 1'b1;
        tick();
        dir_valid = 1'b0;
        dir_req   = 3'd0;
    endtask

    // Layer animation: done_move drops, then rises; commit lands one cycle later.
    task automatic finish_move();
        done_move = 1'b0;
        tick();
        done_move = 1'b1;
        tick();
        tick();
    endtask

    task automatic good_jump(input logic [2:0] d);
        request(d);
        tick();
        finish_move();
    endtask

    task automatic layer_restart();
        state_qb = 3'b000;
        tick();
        state_qb = 3'b010;
        tick();
        tick();
    endtask

    initial begin
        int waited;
        path = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd4, 3'd2, 3'd4, 3'd4,
                 3'd4, 3'd4, 3'd4, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd4, 3'd2,
                 3'd4, 3'd4, 3'd4, 3'd2, 3'd1, 3'd1, 3'd4, 3'd2, 3'd4, 3'd2};
        reset = 1'b1; e_start_qb = 1'b0; dir_valid = 1'b0; dir_req = 3'd0;
        done_move = 1'b1; state_qb = 3'b010; game_qb = 3'b000;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset values
        chk("rst_position", 32'(position_qb), 32'h1);
        chk("rst_next", 32'(e_next_qb), 32'h1);
        chk("rst_visited", 32'(visited), 32'h1);
        chk("rst_jump", 32'(e_jump_qb), 32'h0);
        chk("rst_bad", 32'(e_bad_jump), 32'h0);
        chk("rst_win", 32'(e_win_qb), 32'h0);
        chk("rst_lives", 32'(lives), 32'h3);
        chk("rst_over", 32'(game_over), 32'h0);
        chk("rst_count", 32'(jump_count), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // First good jump DOWN_RIGHT from TOP
        request(3'd1);
        tick();
        chk("dr_next", 32'(e_next_qb), 32'h2);
        chk("dr_jump", 32'(e_jump_qb), 32'h1);
        chk("dr_bad", 32'(e_bad_jump), 32'h0);
        chk("dr_busy", 32'(busy), 32'h1);
        finish_move();
        chk("dr_position", 32'(position_qb), 32'h2);
        chk("dr_visited", 32'(visited), 32'h3);
        chk("dr_count", 32'(jump_count), 32'h1);
        chk("dr_jump_clr", 32'(e_jump_qb), 32'h0);
        chk("dr_busy_clr", 32'(busy), 32'h0);

        // Illegal direction code is dropped
        request(3'd5);
        tick();
        chk("illegal_busy", 32'(busy), 32'h0);
        chk("illegal_jump", 32'(e_jump_qb), 32'h0);

        // Restart
        restart();
        chk("restart_position", 32'(position_qb), 32'h1);
        chk("restart_visited", 32'(visited), 32'h1);
        chk("restart_count", 32'(jump_count), 32'h0);

        // UP_RIGHT from TOP leaves the pyramid
        request(3'd3);
        tick();
        chk("top_ur_next", 32'(e_next_qb), 32'h0);
        chk("top_ur_bad", 32'(e_bad_jump), 32'h1);
        finish_move();
        chk("top_ur_lives", 32'(lives), 32'h2);
        chk("top_ur_position", 32'(position_qb), 32'h1);
        chk("top_ur_busy", 32'(busy), 32'h1);
        layer_restart();
        chk("recover_position", 32'(position_qb), 32'h1);
        chk("recover_bad", 32'(e_bad_jump), 32'h0);
        chk("recover_next", 32'(e_next_qb), 32'h1);
        chk("recover_busy", 32'(busy), 32'h0);

        // Row 7 col 0, DOWN_LEFT is off the pyramid
        for (int i = 0; i < 6; i++) good_jump(3'd1);
        chk("r7c0_position", 32'(position_qb), 32'h0020_0000);
        request(3'd2);
        tick();
        chk("r7c0_dl_next", 32'(e_next_qb), 32'h0);
        chk("r7c0_dl_bad", 32'(e_bad_jump), 32'h1);
        finish_move();
        chk("r7c0_lives", 32'(lives), 32'h1);
        layer_restart();

        // Row 7 col 6, UP_LEFT is off the pyramid; then restart mid-move
        restart();
        chk("restart2_lives", 32'(lives), 32'h3);
        for (int i = 0; i < 6; i++) good_jump(3'd2);
        chk("r7c6_position", 32'(position_qb), 32'h0800_0000);
        request(3'd4);
        tick();
        chk("r7c6_ul_next", 32'(e_next_qb), 32'h0);
        chk("r7c6_ul_bad", 32'(e_bad_jump), 32'h1);
        done_move = 1'b0;
        tick();
        restart();
        chk("midmove_jump", 32'(e_jump_qb), 32'h0);
        chk("midmove_bad", 32'(e_bad_jump), 32'h0);
        chk("midmove_busy", 32'(busy), 32'h0);
        done_move = 1'b1;
        tick(); tick();
        chk("midmove_position", 32'(position_qb), 32'h1);
        chk("midmove_lives", 32'(lives), 32'h3);
        chk("midmove_count", 32'(jump_count), 32'h0);

        // Bit 4 (row 3 col 1), UP_RIGHT lands on bit 1
        good_jump(3'd1);
        good_jump(3'd2);
        chk("bit4_position", 32'(position_qb), 32'h10);
        request(3'd3);
        tick();
        chk("bit4_ur_next", 32'(e_next_qb), 32'h2);
        chk("bit4_ur_bad", 32'(e_bad_jump), 32'h0);
        finish_move();
        chk("bit4_ur_position", 32'(position_qb), 32'h2);

        // Saucer while READY: respawn at TOP after the layer restarts
        state_qb = 3'b011;
        tick();
        tick();
        chk("saucer_busy", 32'(busy), 32'h1);
        layer_restart();
        chk("saucer_position", 32'(position_qb), 32'h1);
        chk("saucer_busy_clr", 32'(busy), 32'h0);

        // Full-map walk ending in a win
        restart();
        for (int i = 0; i < 29; i++) good_jump(path[i]);
        chk("walk_visited", 32'(visited), 32'h07FF_FFFF);
        chk("walk_win_early", 32'(e_win_qb), 32'h0);
        request(path[29]);
        tick();
        chk("win_flag", 32'(e_win_qb), 32'h1);
        chk("win_jump", 32'(e_jump_qb), 32'h2);
        chk("win_next", 32'(e_next_qb), 32'h0800_0000);
        finish_move();
        chk("win_visited", 32'(visited), 32'h0FFF_FFFF);
        chk("win_count", 32'(jump_count), 32'd30);
        chk("win_hold", 32'(e_win_qb), 32'h1);
        request(3'd3);
        tick();
        chk("win_ignore_busy", 32'(busy), 32'h0);
        chk("win_ignore_jump", 32'(e_jump_qb), 32'h0);
        restart();
        chk("win_restart", 32'(e_win_qb), 32'h0);

        // Three bad jumps end the game
        for (int i = 0; i < 3; i++) begin
            request(3'd3);
            tick();
            finish_move();
            if (i < 2) layer_restart();
        end
        chk("over_lives", 32'(lives), 32'h0);
        chk("over_flag", 32'(game_over), 32'h1);
        state_qb = 3'b010;
        request(3'd1);
        tick();
        chk("over_ignore_jump", 32'(e_jump_qb), 32'h0);
        chk("over_busy", 32'(busy), 32'h1);
        restart();
        chk("over_restart_lives", 32'(lives), 32'h3);
        chk("over_restart_visited", 32'(visited), 32'h1);
        chk("over_restart_flag", 32'(game_over), 32'h0);

        // Paused game drops the request
        game_qb = 3'b001;
        request(3'd1);
        tick();
        chk("pause_jump", 32'(e_jump_qb), 32'h0);
        chk("pause_busy", 32'(busy), 32'h0);
        game_qb = 3'b000;

        // Layer never drops done_move: launch times out
        request(3'd1);
        tick();
        chk("timeout_issue", 32'(e_jump_qb), 32'h1);
        waited = 0;
        while (busy && waited < 1200) begin
            tick();
            waited++;
        end
        chk("timeout_busy", 32'(busy), 32'h0);
        chk("timeout_jump", 32'(e_jump_qb), 32'h0);
        chk("timeout_len", 32'((waited >= 1020) && (waited <= 1030)), 32'h1);
        chk("timeout_position", 32'(position_qb), 32'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
